// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Round-robin arbiter and sequencer for a shared 2:1 data mux. Two requesters
// (A, B) share one downstream channel. A grant is held for a whole packet (up
// to the owner's last beat). Ownership alternates fairly between requesters.
// A packet that reaches MAX_BEATS beats is cut and flagged.
//
// Handshake: a beat moves downstream when out_valid & out_ready are both high
// at a rising clk edge. Upstream, a beat from requester x is consumed when
// req_x & gnt_x are both high at that edge. gnt_x is only ever high for the
// current owner. req and data must stay stable until consumed.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_a/b              requester has a valid beat
//   data_a/b, last_a/b   beat payload and end-of-packet marker
//   gnt_a/b              grant (owner only, follows out_ready)
//   out_valid/data/last  downstream beat (last forced high at the beat limit)
//   out_ready            downstream accepts
//   sel                  registered mux select (0=A, 1=B)
//   busy                 a grant is held
//   trunc                one-cycle pulse after a packet was cut at MAX_BEATS
//   state_dbg            raw FSM state (0=IDLE, 1=OWN)
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy,
  output logic             trunc,
  output logic             state_dbg
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic             sel_n;
  logic             prio, prio_n;
  logic [CNT_W-1:0] beat_cnt, cnt_n;
  logic             trunc_n;

  logic             owner_req;
  logic             owner_last;
  logic             at_limit;

  // sel is registered and only moves on IDLE->OWN, so the owner's view is
  // stable for the whole packet.
  assign owner_req  = sel ? req_b  : req_a;
  assign owner_last = sel ? last_b : last_a;
  assign at_limit   = (beat_cnt == LAST_CNT);

  assign out_data  = sel ? data_b : data_a;
  assign busy      = (state == OWN);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      prio     <= 1'b0;
      beat_cnt <= '0;
      trunc    <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      prio     <= prio_n;
      beat_cnt <= cnt_n;
      trunc    <= trunc_n;
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    prio_n    = prio;
    cnt_n     = beat_cnt;
    trunc_n   = 1'b0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          state_n = OWN;
          cnt_n   = '0;
          // On a tie prio decides; otherwise the lone requester wins.
          sel_n   = (req_a & req_b) ? prio : req_b;
        end
      end
      OWN: begin
        out_valid = owner_req;
        gnt_a     = ~sel & out_ready;
        gnt_b     = sel & out_ready;
        out_last  = owner_last | at_limit;
        if (owner_req & out_ready) begin
          cnt_n = beat_cnt + 1'b1;
          if (out_last) begin
            state_n = IDLE;
            prio_n  = ~sel;
            // Flag only a forced end; a real last on the limit beat is normal.
            trunc_n = ~owner_last;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req_a = 0, req_b = 0, last_a = 0, last_b = 0, out_ready = 0;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic         gnt_a, gnt_b, out_valid, out_last, sel, busy, trunc, state_dbg;
  logic [W-1:0] out_data;

  mux2_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .last_a(last_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .busy(busy), .trunc(trunc),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Producer queues: {last, data}. Observed transfers: {sel, last, data}.
  logic [W:0]   qa[$], qb[$];
  logic [W+1:0] obs_q[$];
  int           obs_cyc[$];
  logic [W+1:0] exp_q[$];
  bit           acc_a, acc_b;
  int           cyc, trunc_cnt;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_a = 0; req_b = 0; last_a = 0; last_b = 0; out_ready = 0;
    qa.delete(); qb.delete(); obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    acc_a = 0; acc_b = 0; cyc = 0; trunc_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: retire beats accepted at the previous edge, drive the producers,
  // then sample combinational outputs 1ns after the falling edge.
  task automatic run_cycle(input bit a_en, input bit b_en, input bit rdy);
    logic [W:0] tmp;
    @(negedge clk);
    if (acc_a && qa.size() > 0) tmp = qa.pop_front();
    if (acc_b && qb.size() > 0) tmp = qb.pop_front();
    req_a  = a_en && (qa.size() > 0);
    data_a = (qa.size() > 0) ? qa[0][W-1:0] : W'($urandom);
    last_a = (qa.size() > 0) ? qa[0][W] : 1'b0;
    req_b  = b_en && (qb.size() > 0);
    data_b = (qb.size() > 0) ? qb[0][W-1:0] : W'($urandom);
    last_b = (qb.size() > 0) ? qb[0][W] : 1'b0;
    out_ready = rdy;
    #1;
    acc_a = req_a & gnt_a;
    acc_b = req_b & gnt_b;
    if (out_valid && out_ready) begin
      obs_q.push_back({sel, out_last, out_data});
      obs_cyc.push_back(cyc);
    end
    if (trunc) trunc_cnt++;
    cyc++;
  endtask

  task automatic push_pkt(input bit to_b, input logic [W-1:0] base, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      logic [W:0] e;
      e = {(with_last && i == len - 1), W'(base + W'(i))};
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W+1:0] exp3[3];
    int k;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_a = 1'($urandom); req_b = 1'($urandom); last_a = 1'($urandom);
      last_b = 1'($urandom); out_ready = 1'($urandom);
      data_a = W'($urandom); data_b = W'($urandom);
      #1;
      n_checks++;
      if ({busy, sel, gnt_a, gnt_b, out_valid, trunc, out_last} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: busy/sel/gnt_a/gnt_b/valid/trunc/last=%b required 0000000", {busy, sel, gnt_a, gnt_b, out_valid, trunc, out_last});
      end
      n_checks++;
      if (out_data !== data_a) begin
        n_fail++;
        $display("FAIL reset_out_data: got %h required %h", out_data, data_a);
      end
    end
    do_reset();
    qa.push_back({1'b0, 8'h11}); qa.push_back({1'b0, 8'h22}); qa.push_back({1'b1, 8'h33});
    exp3[0] = {1'b0, 1'b0, 8'h11}; exp3[1] = {1'b0, 1'b0, 8'h22}; exp3[2] = {1'b0, 1'b1, 8'h33};
    k = 0;
    while (obs_q.size() < 3 && k < 20) begin run_cycle(1, 0, 1); k++; end
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL reset_pkt_count: got %0d transfers required 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[i] !== exp3[i]) begin
          n_fail++;
          $display("FAIL reset_pkt_beat%0d: got %h required %h", i, obs_q[i], exp3[i]);
        end
      end
    end
    run_cycle(1, 0, 1);
    n_checks++;
    if (busy !== 1'b0 || obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL reset_pkt_release: busy=%b transfers=%0d required busy=0 transfers=3", busy, obs_q.size());
    end
  endtask

  task automatic test_alternation();
    logic [W+1:0] exp8[8];
    int k;
    do_reset();
    push_pkt(0, 8'hA0, 2, 1); push_pkt(0, 8'hA2, 2, 1);
    push_pkt(1, 8'hB0, 2, 1); push_pkt(1, 8'hB2, 2, 1);
    exp8[0] = {2'b00, 8'hA0}; exp8[1] = {2'b01, 8'hA1};
    exp8[2] = {2'b10, 8'hB0}; exp8[3] = {2'b11, 8'hB1};
    exp8[4] = {2'b00, 8'hA2}; exp8[5] = {2'b01, 8'hA3};
    exp8[6] = {2'b10, 8'hB2}; exp8[7] = {2'b11, 8'hB3};
    k = 0;
    while (obs_q.size() < 8 && k < 40) begin run_cycle(1, 1, 1); k++; end
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL alt_count: got %0d transfers required 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_q[i] !== exp8[i]) begin
          n_fail++;
          $display("FAIL alt_beat%0d: got %h required %h", i, obs_q[i], exp8[i]);
        end
        if (i > 0) begin
          // Contiguous within a packet, exactly one idle cycle between packets.
          n_checks++;
          if (obs_cyc[i] - obs_cyc[i-1] != ((i % 2 == 0) ? 2 : 1)) begin
            n_fail++;
            $display("FAIL alt_gap%0d: got %0d cycles required %0d", i, obs_cyc[i] - obs_cyc[i-1], (i % 2 == 0) ? 2 : 1);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    do_reset();
    push_pkt(1, 8'hC0, 4, 1);
    push_pkt(0, 8'hEE, 1, 1);
    run_cycle(0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      run_cycle(1, 1, pat[i]);
      n_checks++;
      if (sel !== 1'b1 || gnt_a !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: sel=%b gnt_a=%b busy=%b required sel=1 gnt_a=0 busy=1", i, sel, gnt_a, busy);
      end
    end
    n_checks++;
    if (obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d transfers required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== {1'b1, (i == 3), W'(8'hC0 + i)}) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], {1'b1, (i == 3), W'(8'hC0 + i)});
        end
      end
    end
    run_cycle(0, 0, 1);
    n_checks++;
    if (busy !== 1'b0 || trunc_cnt != 0) begin
      n_fail++;
      $display("FAIL bp_release: busy=%b trunc_pulses=%0d required 0 and 0", busy, trunc_cnt);
    end
  endtask

  task automatic test_truncation();
    int k;
    do_reset();
    push_pkt(0, 8'h40, 6, 0);
    push_pkt(1, 8'h50, 2, 1);
    k = 0;
    while (obs_q.size() < 5 && k < 30) begin run_cycle(1, 1, 1); k++; end
    n_checks++;
    if (obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL trunc_count: got %0d transfers required 5", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== {1'b0, (i == 3), W'(8'h40 + i)}) begin
          n_fail++;
          $display("FAIL trunc_beat%0d: got %h required %h", i, obs_q[i], {1'b0, (i == 3), W'(8'h40 + i)});
        end
      end
      n_checks++;
      if (obs_q[4] !== {2'b10, 8'h50}) begin
        n_fail++;
        $display("FAIL trunc_next_owner: got %h required %h", obs_q[4], {2'b10, 8'h50});
      end
    end
    run_cycle(1, 1, 1); run_cycle(1, 1, 1);
    n_checks++;
    if (trunc_cnt != 1) begin
      n_fail++;
      $display("FAIL trunc_pulse: got %0d pulses required 1", trunc_cnt);
    end
  endtask

  task automatic test_stall();
    int k;
    do_reset();
    push_pkt(0, 8'h60, 4, 1);
    push_pkt(1, 8'h70, 2, 1);
    k = 0;
    while (obs_q.size() < 2 && k < 10) begin run_cycle(1, 1, 1); k++; end
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 1, 1);
      n_checks++;
      if (busy !== 1'b1 || sel !== 1'b0 || out_valid !== 1'b0 || gnt_b !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: busy=%b sel=%b valid=%b gnt_b=%b required 1 0 0 0", i, busy, sel, out_valid, gnt_b);
      end
    end
    k = 0;
    while (obs_q.size() < 5 && k < 20) begin run_cycle(1, 1, 1); k++; end
    n_checks++;
    if (obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL stall_count: got %0d transfers required 5", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== {1'b0, (i == 3), W'(8'h60 + i)}) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h required %h", i, obs_q[i], {1'b0, (i == 3), W'(8'h60 + i)});
        end
      end
      n_checks++;
      if (obs_q[4] !== {2'b10, 8'h70} || trunc_cnt != 0) begin
        n_fail++;
        $display("FAIL stall_finish: next=%h trunc_pulses=%0d required %h and 0", obs_q[4], trunc_cnt, {2'b10, 8'h70});
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    push_pkt(0, 8'h80, 2, 1);
    push_pkt(1, 8'h90, 5, 1);
    k = 0;
    while (obs_q.size() < 2 && k < 10) begin run_cycle(1, 0, 1); k++; end
    k = 0;
    while (obs_q.size() < 3 && k < 10) begin run_cycle(0, 1, 1); k++; end
    run_cycle(0, 1, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h91) begin
      n_fail++;
      $display("FAIL mid_beat2: valid=%b data=%h required 1 and 91", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abort: valid=%b busy=%b last=%b required 0 0 0", out_valid, busy, out_last);
    end
    do_reset();
    push_pkt(0, 8'hA8, 1, 1);
    push_pkt(1, 8'hB8, 1, 1);
    k = 0;
    while (obs_q.size() < 1 && k < 10) begin run_cycle(1, 1, 1); k++; end
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {2'b01, 8'hA8}) begin
      n_fail++;
      $display("FAIL mid_first_grant: transfers=%0d first=%h required 1 and %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, {2'b01, 8'hA8});
    end
  endtask

  // Randomised traffic against a cycle-level rule model of the arbiter.
  task automatic test_random();
    bit m_own, m_sel, m_prio, m_trunc, o_last, e_valid, e_gnt_a, e_gnt_b, e_last;
    int m_cnt, k;
    logic [W+1:0] got, want;
    do_reset();
    m_own = 0; m_sel = 0; m_prio = 0; m_trunc = 0; m_cnt = 0;
    for (int p = 0; p < 10; p++) begin
      push_pkt(0, W'($urandom), $urandom_range(1, 6), 1);
      push_pkt(1, W'($urandom), $urandom_range(1, 6), 1);
    end
    k = 0;
    while ((qa.size() > 0 || qb.size() > 0 || m_own) && k < 3000) begin
      run_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
      k++;
      o_last  = m_sel ? last_b : last_a;
      e_valid = m_own && (m_sel ? req_b : req_a);
      e_gnt_a = m_own && !m_sel && out_ready;
      e_gnt_b = m_own && m_sel && out_ready;
      e_last  = m_own && (o_last || m_cnt == MB - 1);
      n_checks++;
      if ({busy, sel, gnt_a, gnt_b, out_valid, out_last, trunc} !== {m_own, m_sel, e_gnt_a, e_gnt_b, e_valid, e_last, m_trunc}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc%0d: busy/sel/gnt_a/gnt_b/valid/last/trunc=%b required %b", k, {busy, sel, gnt_a, gnt_b, out_valid, out_last, trunc}, {m_own, m_sel, e_gnt_a, e_gnt_b, e_valid, e_last, m_trunc});
      end
      if (!m_own) begin
        m_trunc = 0;
        if (req_a || req_b) begin
          m_own = 1;
          m_sel = (req_a && req_b) ? m_prio : req_b;
          m_cnt = 0;
        end
      end else begin
        m_trunc = 0;
        if (e_valid && out_ready) begin
          exp_q.push_back({m_sel, e_last, m_sel ? data_b : data_a});
          m_cnt++;
          if (e_last) begin
            m_own = 0;
            m_prio = !m_sel;
            m_trunc = !o_last;
          end
        end
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        got = obs_q.pop_front();
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL rand_beat cyc%0d: got %h required %h", k, got, want);
        end
      end
    end
    n_checks++;
    if (k >= 3000 || obs_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: cycles=%0d leftover obs=%0d exp=%0d required all drained", k, obs_q.size(), exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    acc_a = 0; acc_b = 0; cyc = 0; trunc_cnt = 0;
    test_reset();
    test_alternation();
    test_backpressure();
    test_truncation();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and sequencer for the shared 2-to-1 data mux. It lets two requesters, A and B, share one downstream channel. It owns the mux select, holds a grant for a whole packet (up to `last`), and alternates fairly between requesters. A beat limit truncates runaway packets. It sits between two producers and the single consumer port that the 2:1 mux feeds.

## Interface
- `WIDTH`, 8: data width of each requester and of the output.
- `MAX_BEATS`, 16: maximum beats per grant. Must be ≥2. The counter width is clog2(MAX_BEATS).
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_a` / `req_b`  in  1  requester has a valid beat.
- `data_a` / `data_b`  in  WIDTH  beat data.
- `last_a` / `last_b`  in  1  beat is the final beat of its packet.
- `gnt_a` / `gnt_b`  out  1  the beat is accepted this cycle when `req_x & gnt_x`.
- `out_valid`  out  1  downstream beat valid.
- `out_data`  out  WIDTH  mux output; equals `data_a` when `sel`=0 and `data_b` when `sel`=1.
- `out_last`  out  1  muxed `last`, or forced high on truncation.
- `out_ready`  in  1  downstream accepts.
- `sel`  out  1  registered mux select (0=A, 1=B).
- `busy`  out  1  a grant is held (state OWN).
- `trunc`  out  1  one-cycle registered pulse when a packet is cut at MAX_BEATS.

## Operation
- Two states: IDLE and OWN.
- Register `prio`: 0 means A wins a tie, 1 means B wins. It is set to the complement of the owner on each release.
- **IDLE behaviour:**
  - Outputs are `gnt_a`=`gnt_b`=0 and `out_valid`=0.
  - If only `req_a` is high: `sel`←0, go to OWN.
  - If only `req_b` is high: `sel`←1, go to OWN.
  - If both are high: `sel`←`prio`, go to OWN.
  - If neither is high: stay in IDLE.
  - `beat_cnt`←0 on entry to OWN.
- **OWN behaviour:**
  - `out_valid` = req of the owner.
  - `gnt_x` = (`sel`==x) & `out_ready`. The non-owner's grant is always 0.
  - `out_last` = last of the owner | (`beat_cnt`==MAX_BEATS-1).
  - A transfer is `out_valid & out_ready`. Each transfer increments `beat_cnt`.
  - On a transfer with `out_last`=1: go to IDLE and set `prio`←~`sel`.
  - If that transfer had owner last=0 (forced end), `trunc`←1 for one cycle.
- The owner may drop req mid-packet. The grant stays locked, no beat is counted, and `out_valid`=0. There is no timeout.
- The non-owner's req is ignored until release. Its data never reaches the output.
- `sel` changes only on the IDLE→OWN edge. It is stable for the whole packet, so no glitch reaches the mux.

## Timing
- **Reset values** (`rst`=1, asynchronous):
  - state=IDLE, `sel`=0, `prio`=0, `beat_cnt`=0, `trunc`=0.
  - Hence `busy`=0, `gnt_a`=`gnt_b`=0, `out_valid`=0, `out_last`=0, `out_data`=`data_a`.
- Reset asserted mid-packet aborts the packet immediately. The downstream sees `out_valid` fall in the same cycle. No `last` is emitted.
- **Arbitration latency:** a req seen in IDLE at edge N gives `busy`=1 and a valid `sel` after N. The earliest transfer is in the cycle following edge N.
- **Release:** the `last` transfer completes at edge M, and the state is IDLE after M. There is one mandatory idle cycle, so the next grant has `busy`=1 after edge M+1.
- **Throughput:** at most MAX_BEATS beats per MAX_BEATS+1 cycles.
- `gnt_x` and `out_valid` are combinational from the registered state and the live `req`/`out_ready`. There is no combinational path from `out_ready` to `sel`.
- **Simultaneous events:**
  - `last` and the `beat_cnt` limit on the same beat: a normal release with `trunc`=0.
  - Release at edge M while the former owner still requests: the other requester wins the next grant if it is requesting.

## Test plan
- **Reset:** hold `rst`, toggle all inputs. `busy`=0, `sel`=0, `gnt`=0, `out_valid`=0, `trunc`=0. Release `rst`, then apply `req_a`=1 with a 3-beat packet 0x11, 0x22, 0x33 (`last` on 0x33) and `out_ready`=1. The output carries exactly those beats, then `busy`=0.
- **Tie-break and alternation:** hold `req_a`=`req_b`=1 with 2-beat packets. Grants go A, B, A, B. Each packet is contiguous and there is one idle cycle between packets.
- **Backpressure:** owner B sends 4 beats while `out_ready` toggles 1,0,0,1,1,0,1. Exactly 4 transfers occur, data is in order, `sel` stays 1 throughout, and `gnt_a` is never 1.
- **Truncation:** with MAX_BEATS=4, A streams with `last`=0. Beat 4 has `out_last`=1, `trunc` pulses once, and B (requesting) is granted next.
- **Owner stall:** `req_a` drops for 3 cycles mid-packet while `req_b`=1. The grant is held, `out_valid`=0, and `beat_cnt` is unchanged. The packet then finishes normally.
- **Reset mid-packet:** assert `rst` on beat 2 of 5. `out_valid` falls the same cycle, and after release the first grant goes to A (`prio`=0).
